// File: rtl/ser_link_scheduler.sv
// Round-robin scheduler sharing one serial link between NREQ requesters; frames advance one bit per clkPB step.
// Optional macro FRAME_PARITY_EN inserts an even-parity bit over PORT/LEN/DATA before the gap.
module ser_link_scheduler #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned GAP_STEPS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clkPB,
    input  logic [NREQ-1:0]          req,
    input  logic [2*NREQ-1:0]        port_in,
    input  logic [4*NREQ-1:0]        len_in,
    input  logic [DATA_W*NREQ-1:0]   data_in,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          done,
    output logic                     serOut,
    output logic                     busy
);

    localparam int unsigned PW  = $clog2(NREQ);
    localparam int unsigned DIW = $clog2(DATA_W);
    localparam logic [3:0]  GAP_LAST = 4'(GAP_STEPS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_PORT,
        S_LEN,
        S_DATA,
`ifdef FRAME_PARITY_EN
        S_PAR,
`endif
        S_GAP
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_sync1, r_sync2, r_sync_d;
    logic                  w_step;
    logic [PW-1:0]         r_ptr;
    logic [PW-1:0]         w_gidx;
    logic                  w_found;
    logic [1:0]            w_port_arr [NREQ];
    logic [3:0]            w_len_arr  [NREQ];
    logic [DATA_W-1:0]     w_data_arr [NREQ];
    logic [1:0]            r_port;
    logic [3:0]            r_len;
    logic [DATA_W-1:0]     r_data;
    logic [3:0]            r_bit_idx;
    logic [3:0]            w_idx_nxt;
    logic [3:0]            w_len_m1;
    logic                  r_ser, w_ser_nxt;
    logic [NREQ-1:0]       r_gnt, w_gnt_nxt;
    logic [NREQ-1:0]       r_done, w_done_nxt;
    logic                  r_busy;
    logic                  w_latch;
    logic                  w_tail_bit;

`ifdef FRAME_PARITY_EN
    localparam state_t S_TAIL = S_PAR;
    logic [DATA_W-1:0]     w_mask;
    assign w_mask     = ~({DATA_W{1'b1}} << r_len);
    assign w_tail_bit = ^r_port ^ ^r_len ^ ^(r_data & w_mask);
`else
    localparam state_t S_TAIL = S_GAP;
    assign w_tail_bit = 1'b1;
`endif

    assign w_len_m1 = 4'(r_len - 4'd1);

    // clkPB synchronizer and rising-edge step pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_sync_d <= 1'b0;
        end else begin
            r_sync1  <= clkPB;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    assign w_step = r_sync2 & ~r_sync_d;

    always_comb begin
        for (int i = 0; i < int'(NREQ); i++) begin
            w_port_arr[i] = port_in[2*i +: 2];
            w_len_arr[i]  = len_in[4*i +: 4];
            w_data_arr[i] = data_in[DATA_W*i +: DATA_W];
        end
    end

    // First pending requester after the pointer, wrapping
    always_comb begin
        logic [PW-1:0] w_cand;
        w_found = 1'b0;
        w_gidx  = '0;
        w_cand  = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            w_cand = PW'((32'(r_ptr) + i) % NREQ);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_gidx  = w_cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_nxt = S_START;
            S_START: if (w_step) w_state_nxt = S_PORT;
            S_PORT:  if (w_step && r_bit_idx == 4'd1) w_state_nxt = S_LEN;
            S_LEN:   if (w_step && r_bit_idx == 4'd3)
                         w_state_nxt = (r_len == 4'd0) ? S_TAIL : S_DATA;
            S_DATA:  if (w_step && r_bit_idx == w_len_m1) w_state_nxt = S_TAIL;
`ifdef FRAME_PARITY_EN
            S_PAR:   if (w_step) w_state_nxt = S_GAP;
`endif
            S_GAP:   if (w_step && r_bit_idx == GAP_LAST) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Each step that enters a state emits that state's first bit
    always_comb begin
        w_ser_nxt  = r_ser;
        w_idx_nxt  = r_bit_idx;
        w_gnt_nxt  = r_gnt;
        w_done_nxt = '0;
        w_latch    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_latch   = 1'b1;
                    w_gnt_nxt = NREQ'(1) << w_gidx;
                    w_ser_nxt = 1'b0;
                    w_idx_nxt = 4'd0;
                end
            end
            S_START: begin
                if (w_step) begin
                    w_ser_nxt = r_port[1];
                    w_idx_nxt = 4'd0;
                end
            end
            S_PORT: begin
                if (w_step) begin
                    if (r_bit_idx == 4'd1) begin
                        w_ser_nxt = r_len[3];
                        w_idx_nxt = 4'd0;
                    end else begin
                        w_ser_nxt = r_port[0];
                        w_idx_nxt = 4'd1;
                    end
                end
            end
            S_LEN: begin
                if (w_step) begin
                    if (r_bit_idx == 4'd3) begin
                        w_idx_nxt = 4'd0;
                        w_ser_nxt = (r_len == 4'd0) ? w_tail_bit : r_data[DIW'(w_len_m1)];
                    end else begin
                        w_idx_nxt = 4'(r_bit_idx + 4'd1);
                        w_ser_nxt = r_len[2'(4'd2 - r_bit_idx)];
                    end
                end
            end
            S_DATA: begin
                if (w_step) begin
                    if (r_bit_idx == w_len_m1) begin
                        w_idx_nxt = 4'd0;
                        w_ser_nxt = w_tail_bit;
                    end else begin
                        w_idx_nxt = 4'(r_bit_idx + 4'd1);
                        w_ser_nxt = r_data[DIW'(4'(r_len - 4'd2 - r_bit_idx))];
                    end
                end
            end
`ifdef FRAME_PARITY_EN
            S_PAR: begin
                if (w_step) begin
                    w_idx_nxt = 4'd0;
                    w_ser_nxt = 1'b1;
                end
            end
`endif
            S_GAP: begin
                if (w_step) begin
                    w_ser_nxt = 1'b1;
                    if (r_bit_idx == GAP_LAST) begin
                        w_idx_nxt  = 4'd0;
                        w_gnt_nxt  = '0;
                        w_done_nxt = r_gnt;
                    end else begin
                        w_idx_nxt = 4'(r_bit_idx + 4'd1);
                    end
                end
            end
            default: begin
                w_ser_nxt = 1'b1;
                w_gnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ser     <= 1'b1;
            r_gnt     <= '0;
            r_done    <= '0;
            r_busy    <= 1'b0;
            r_bit_idx <= 4'd0;
            r_ptr     <= PW'(NREQ - 1);
            r_port    <= 2'd0;
            r_len     <= 4'd0;
            r_data    <= '0;
        end else begin
            r_ser     <= w_ser_nxt;
            r_gnt     <= w_gnt_nxt;
            r_done    <= w_done_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
            r_bit_idx <= w_idx_nxt;
            if (w_latch) begin
                r_ptr  <= w_gidx;
                r_port <= w_port_arr[w_gidx];
                r_len  <= w_len_arr[w_gidx];
                r_data <= w_data_arr[w_gidx];
            end
        end
    end

    assign serOut = r_ser;
    assign gnt    = r_gnt;
    assign done   = r_done;
    assign busy   = r_busy;

endmodule

// File: tb/tb_ser_link_scheduler.sv
// Scoreboard bench for ser_link_scheduler: expected serial bits are queued per grant and popped per step.
module tb_ser_link_scheduler;

    localparam int NREQ      = 4;
    localparam int DATA_W    = 16;
    localparam int GAP_STEPS = 1;

    logic                   clk;
    logic                   rst;
    logic                   clkPB;
    logic [NREQ-1:0]        req;
    logic [2*NREQ-1:0]      port_in;
    logic [4*NREQ-1:0]      len_in;
    logic [DATA_W*NREQ-1:0] data_in;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        done;
    logic                   serOut;
    logic                   busy;

    int n_checks = 0;
    int n_errors = 0;
    int ptr_m;
    bit last_bit;
    bit exp_q[$];

    ser_link_scheduler #(.NREQ(NREQ), .DATA_W(DATA_W), .GAP_STEPS(GAP_STEPS)) dut (
        .clk(clk), .rst(rst), .clkPB(clkPB), .req(req),
        .port_in(port_in), .len_in(len_in), .data_in(data_in),
        .gnt(gnt), .done(done), .serOut(serOut), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int arb_model(input int ptr, input logic [NREQ-1:0] r);
        for (int i = 1; i <= NREQ; i++) begin
            if (r[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
        end
        return -1;
    endfunction

    task automatic set_desc(input int i, input logic [1:0] p, input logic [3:0] l, input logic [15:0] d);
        port_in[2*i +: 2]           = p;
        len_in[4*i +: 4]            = l;
        data_in[DATA_W*i +: DATA_W] = d;
    endtask

    // Start, port, len, data, [parity], gap ones, then the idle '1' seen on the GAP->IDLE step
    task automatic push_frame(input int g);
        logic [1:0]        p;
        logic [3:0]        l;
        logic [DATA_W-1:0] d;
        bit                par;
        p = port_in[2*g +: 2];
        l = len_in[4*g +: 4];
        d = data_in[DATA_W*g +: DATA_W];
        par = 1'b0;
        exp_q.push_back(1'b0);
        for (int b = 1; b >= 0; b--) begin exp_q.push_back(p[b]); par ^= p[b]; end
        for (int b = 3; b >= 0; b--) begin exp_q.push_back(l[b]); par ^= l[b]; end
        for (int b = int'(l) - 1; b >= 0; b--) begin exp_q.push_back(d[b]); par ^= d[b]; end
`ifdef FRAME_PARITY_EN
        exp_q.push_back(par);
`endif
        for (int k = 0; k < GAP_STEPS; k++) exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
    endtask

    task automatic check_grant(input int g);
        bit e;
        logic [NREQ-1:0] oh;
        oh = NREQ'(1) << g;
        e  = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
        n_checks++;
        if ({serOut, gnt, busy, done} !== {e, oh, 1'b1, {NREQ{1'b0}}}) begin
            n_errors++;
            $display("FAIL grant_edge g=%0d: ser=%b gnt=%b busy=%b done=%b, expected ser=%b gnt=%b busy=1 done=0",
                     g, serOut, gnt, busy, done, e, oh);
        end
        last_bit = e;
    endtask

    task automatic run_bits(input int g, input int nbits, input bit final_done);
        bit e;
        logic pre;
        logic [NREQ-1:0] oh;
        oh = NREQ'(1) << g;
        for (int k = 0; k < nbits; k++) begin
            clkPB = 1'b0;
            repeat (3) tick();
            clkPB = 1'b1;
            tick();
            tick();
            pre = serOut;
            n_checks++;
            if (pre !== last_bit) begin
                n_errors++;
                $display("FAIL step_latency step=%0d: ser before 3rd edge=%b, expected %b", k, pre, last_bit);
            end
            tick();
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL scoreboard_underflow step=%0d: queue empty, expected a bit", k);
                e = 1'b1;
            end else begin
                e = exp_q.pop_front();
                if (serOut !== e) begin
                    n_errors++;
                    $display("FAIL ser_bit g=%0d step=%0d: got %b expected %b", g, k, serOut, e);
                end
            end
            last_bit = e;
            n_checks++;
            if (final_done && k == nbits - 1) begin
                if ({done, gnt, busy} !== {oh, {NREQ{1'b0}}, 1'b0}) begin
                    n_errors++;
                    $display("FAIL frame_end g=%0d: done=%b gnt=%b busy=%b, expected done=%b gnt=0 busy=0",
                             g, done, gnt, busy, oh);
                end
            end else if ({done, gnt, busy} !== {{NREQ{1'b0}}, oh, 1'b1}) begin
                n_errors++;
                $display("FAIL mid_frame g=%0d step=%0d: done=%b gnt=%b busy=%b, expected done=0 gnt=%b busy=1",
                         g, k, done, gnt, busy, oh);
            end
        end
        clkPB = 1'b0;
    endtask

    task automatic apply_reset;
        clkPB = 1'b0;
        req   = '0;
        rst   = 1'b0;
        exp_q.delete();
        repeat (2) tick();
        rst = 1'b1;
        repeat (3) tick();
        ptr_m = NREQ - 1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #5 clkPB = ~clkPB;
            n_checks++;
            if ({serOut, gnt, busy, done} !== {1'b1, {NREQ{1'b0}}, 1'b0, {NREQ{1'b0}}}) begin
                n_errors++;
                $display("FAIL reset_hold i=%0d: ser=%b gnt=%b busy=%b done=%b, expected 1/0/0/0",
                         i, serOut, gnt, busy, done);
            end
        end
        clkPB = 1'b0;
        tick();
        rst = 1'b1;
        repeat (4) begin
            tick();
            n_checks++;
            if ({serOut, gnt, busy, done} !== {1'b1, {NREQ{1'b0}}, 1'b0, {NREQ{1'b0}}}) begin
                n_errors++;
                $display("FAIL reset_release: ser=%b gnt=%b busy=%b done=%b, expected 1/0/0/0",
                         serOut, gnt, busy, done);
            end
        end
    endtask

    task automatic test_single_frame(input int r, input logic [1:0] p, input logic [3:0] l, input logic [15:0] d);
        int g;
        apply_reset();
        set_desc(r, p, l, d);
        req = NREQ'(1) << r;
        g = arb_model(ptr_m, req);
        ptr_m = g;
        push_frame(g);
        tick();
        check_grant(g);
        req = '0;
        set_desc(r, ~p, ~l, ~d);
        run_bits(g, exp_q.size(), 1'b1);
        tick();
        n_checks++;
        if ({done, gnt, busy, serOut} !== {{NREQ{1'b0}}, {NREQ{1'b0}}, 1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL after_done r=%0d: done=%b gnt=%b busy=%b ser=%b, expected 0/0/0/1",
                     r, done, gnt, busy, serOut);
        end
    endtask

    task automatic test_round_robin;
        int g;
        apply_reset();
        set_desc(0, 2'b11, 4'd2, 16'h0002);
        set_desc(1, 2'b00, 4'd1, 16'h0001);
        set_desc(2, 2'b01, 4'd0, 16'hFFFF);
        set_desc(3, 2'b10, 4'd4, 16'h000A);
        req = '1;
        tick();
        for (int f = 0; f < 5; f++) begin
            g = arb_model(ptr_m, req);
            ptr_m = g;
            push_frame(g);
            check_grant(g);
            run_bits(g, exp_q.size(), 1'b1);
            if (f == 4) req = '0;
            tick();
            n_checks++;
            if (done !== '0) begin
                n_errors++;
                $display("FAIL rr_done_width f=%0d: done=%b, expected 0", f, done);
            end
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL rr_final_idle: busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_reset_mid_frame;
        int g;
        apply_reset();
        set_desc(0, 2'b11, 4'd8, 16'h00A5);
        req = 4'b0001;
        g = arb_model(ptr_m, req);
        ptr_m = g;
        push_frame(g);
        tick();
        check_grant(g);
        run_bits(g, 9, 1'b0);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({serOut, gnt, busy, done} !== {1'b1, {NREQ{1'b0}}, 1'b0, {NREQ{1'b0}}}) begin
            n_errors++;
            $display("FAIL async_abort: ser=%b gnt=%b busy=%b done=%b, expected 1/0/0/0",
                     serOut, gnt, busy, done);
        end
        exp_q.delete();
        req = 4'b0011;
        set_desc(1, 2'b01, 4'd1, 16'h0000);
        repeat (2) begin
            tick();
            n_checks++;
            if (done !== '0) begin
                n_errors++;
                $display("FAIL abort_no_done: done=%b, expected 0", done);
            end
        end
        rst = 1'b1;
        ptr_m = NREQ - 1;
        g = arb_model(ptr_m, req);
        ptr_m = g;
        push_frame(g);
        tick();
        check_grant(g);
        req = '0;
        run_bits(g, exp_q.size(), 1'b1);
        tick();
    endtask

    initial begin
        rst     = 1'b1;
        clkPB   = 1'b0;
        req     = '0;
        port_in = '0;
        len_in  = '0;
        data_in = '0;
        #1;
        test_reset();
        test_single_frame(0, 2'b10, 4'd3, 16'h0005);
        test_single_frame(2, 2'b01, 4'd0, 16'hFFFF);
        test_single_frame(3, 2'b11, 4'd15, 16'h5A3C);
        test_round_robin();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
